pc_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for the 16-bit RISC program counter.
//   - Drives the PC enable/jump/target inputs (E, J, B).
//   - Fetches each instruction over a req/ack handshake and holds it in the IR.
//   - Hands non-control ops to the datapath via start/done and resolves JMP/BEQZ itself.
//   - Sits between the PC, instruction memory and the execute datapath.

---
 rtl/pc_seq_ctrl_if.sv | 26 ++
 rtl/pc_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_ctrl_if.sv
// Sequencer-facing bundle: instruction fetch handshake, execute handshake and PC control.
// The master side is the sequencer; the slave side is memory, datapath and PC.
interface pc_seq_ctrl_if #(
   parameter int DW = 16
);
   logic          imem_req;
   logic          imem_ack;
   logic [DW-1:0] imem_rdata;
   logic          exe_start;
   logic          exe_done;
   logic          zero_flag;
   logic [DW-1:0] pc_addr;
   logic          pc_en;
   logic          pc_jump;
   logic [DW-1:0] pc_target;

   modport master (
      output imem_req, exe_start, pc_en, pc_jump, pc_target,
      input  imem_ack, imem_rdata, exe_done, zero_flag, pc_addr
   );

   modport slave (
      input  imem_req, exe_start, pc_en, pc_jump, pc_target,
      output imem_ack, imem_rdata, exe_done, zero_flag, pc_addr
   );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/update sequencer for the 16-bit RISC PC.
// JMP/BEQZ are resolved locally; every other opcode is handed to the datapath.
module pc_seq_ctrl #(
   parameter int          DW        = 16,
   parameter logic [3:0]  OP_HALT   = 4'hF,
   parameter logic [3:0]  OP_JMP    = 4'hC,
   parameter logic [3:0]  OP_BEQZ   = 4'hD,
   parameter int          FETCH_TMO = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                stall,
   output logic [DW-1:0]       ir,
   output logic                halted,
   output logic                fault,
   output logic [2:0]          state,
   pc_seq_ctrl_if.master       bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_UPDATE = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam int          TW       = $clog2(FETCH_TMO + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TMO - 1);

   state_t        state_q, state_d;
   logic [DW-1:0] ir_q, ir_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          fault_q, fault_d;
   logic          jump_q, jump_d;
   logic [DW-1:0] target_q, target_d;
   logic          start_q, start_d;
   logic          run_q, run_d;

   logic [3:0]           op;
   logic signed [DW-1:0] br_off;
   logic [DW-1:0]        br_tgt;
   logic [DW-1:0]        jmp_tgt;

   assign op      = ir_q[DW-1 -: 4];
   assign br_off  = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
   assign br_tgt  = bus.pc_addr + DW'(1) + br_off;
   // JMP stays inside the current 4K page: keep the page bits of the PC.
   assign jmp_tgt = {bus.pc_addr[DW-1 -: 4], ir_q[DW-5:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         ir_q     <= '0;
         cnt_q    <= '0;
         fault_q  <= 1'b0;
         jump_q   <= 1'b0;
         target_q <= '0;
         start_q  <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         cnt_q    <= cnt_d;
         fault_q  <= fault_d;
         jump_q   <= jump_d;
         target_q <= target_d;
         start_q  <= start_d;
         run_q    <= run_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      cnt_d    = cnt_q;
      fault_d  = fault_q;
      jump_d   = jump_q;
      target_d = target_q;
      start_d  = 1'b0;
      run_d    = run;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               cnt_d   = '0;
               state_d = S_DECODE;
            end else if (cnt_q == TMO_LAST) begin
               cnt_d   = '0;
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_DECODE: begin
            if (op == OP_HALT) begin
               state_d = S_HALT;
            end else if (op == OP_JMP) begin
               jump_d   = 1'b1;
               target_d = jmp_tgt;
               state_d  = S_UPDATE;
            end else if (op == OP_BEQZ) begin
               jump_d   = bus.zero_flag;
               target_d = bus.zero_flag ? br_tgt : '0;
               state_d  = S_UPDATE;
            end else begin
               jump_d   = 1'b0;
               target_d = '0;
               start_d  = 1'b1;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            // exe_done may coincide with the start pulse.
            if (bus.exe_done) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            if (!stall) state_d = S_FETCH;
         end
         S_HALT: begin
            if (run && !run_q) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode straight from flops so reset clears them without a clock.
   always_comb begin
      bus.imem_req  = (state_q == S_FETCH);
      bus.exe_start = start_q;
      bus.pc_en     = (state_q == S_UPDATE) && !stall;
      bus.pc_jump   = jump_q;
      bus.pc_target = target_q;
      halted        = (state_q == S_HALT);
      fault         = fault_q;
      ir            = ir_q;
      state         = state_q;
   end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed, table-driven bench for pc_seq_ctrl plus hand sequences for
// fetch timeout recovery and asynchronous reset during UPDATE.
module tb_pc_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        stall;
   logic [15:0] ir;
   logic        halted;
   logic        fault;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;

   pc_seq_ctrl_if #(.DW(16)) bus_if ();

   pc_seq_ctrl #(.DW(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .stall  (stall),
      .ir     (ir),
      .halted (halted),
      .fault  (fault),
      .state  (state),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        run;
      logic        ack;
      logic [15:0] rdata;
      logic        done;
      logic        zero;
      logic        stall;
      logic [15:0] pc;
      logic [2:0]  st;
      logic        req;
      logic        start;
      logic        en;
      logic        jmp;
      logic        upd;
      logic [15:0] tgt;
      logic        hlt;
      logic        flt;
      logic [15:0] ir;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic a, input logic [15:0] rd,
                      input logic d, input logic z, input logic s, input logic [15:0] pc,
                      input logic [2:0] st, input logic rq, input logic sta, input logic en,
                      input logic j, input logic u, input logic [15:0] tg,
                      input logic h, input logic f, input logic [15:0] irx);
      vec_t v;
      v.run = r; v.ack = a; v.rdata = rd; v.done = d; v.zero = z; v.stall = s; v.pc = pc;
      v.st = st; v.req = rq; v.start = sta; v.en = en; v.jmp = j; v.upd = u; v.tgt = tg;
      v.hlt = h; v.flt = f; v.ir = irx;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; run = 1'b0; stall = 1'b0;
      bus_if.imem_ack = 1'b0; bus_if.imem_rdata = '0; bus_if.exe_done = 1'b0;
      bus_if.zero_flag = 1'b0; bus_if.pc_addr = '0;

      //    run ack rdata     done z s pc       | st req sta en j u tgt      h f ir
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000);
      add(1, 0, 16'h0000, 0, 0, 0, 16'h0100,  0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);
      add(1, 1, 16'h1234, 0, 0, 0, 16'h0100,  1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);
      add(0, 1, 16'hFFFF, 0, 0, 0, 16'h0100,  2, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h1234);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0100,  3, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h1234);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0100,  3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h1234);
      add(0, 0, 16'h0000, 1, 0, 0, 16'h0100,  3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h1234);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0100,  4, 0, 0, 1, 0, 1, 16'h0000, 0, 0, 16'h1234);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0101,  1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h1234);
      add(0, 1, 16'hC0A5, 0, 0, 0, 16'h3010,  1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h1234);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h3010,  2, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hC0A5);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h3010,  4, 0, 0, 1, 1, 1, 16'h30A5, 0, 0, 16'hC0A5);
      add(0, 1, 16'hD0FE, 0, 0, 0, 16'h0000,  1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hC0A5);
      add(0, 0, 16'h0000, 0, 1, 0, 16'h0000,  2, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hD0FE);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000,  4, 0, 0, 1, 1, 1, 16'hFFFF, 0, 0, 16'hD0FE);
      add(0, 1, 16'hD0FE, 0, 0, 0, 16'h0000,  1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hD0FE);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000,  2, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hD0FE);
      add(0, 0, 16'h0000, 0, 0, 1, 16'h0000,  4, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'hD0FE);
      add(0, 0, 16'h0000, 0, 0, 1, 16'h0000,  4, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'hD0FE);
      add(0, 0, 16'h0000, 0, 0, 1, 16'h0000,  4, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'hD0FE);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000,  4, 0, 0, 1, 0, 1, 16'h0000, 0, 0, 16'hD0FE);
      add(0, 1, 16'hF000, 0, 0, 0, 16'h0001,  1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hD0FE);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0001,  2, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hF000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0001,  5, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'hF000);
      add(1, 0, 16'h0000, 0, 0, 0, 16'h0001,  5, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'hF000);
      add(1, 0, 16'h0000, 0, 0, 0, 16'h0001,  1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'hF000);

      // Reset state
      step();
      chk("reset state", state, 3'd0);
      chk("reset imem_req", bus_if.imem_req, 1'b0);
      chk("reset pc_en", bus_if.pc_en, 1'b0);
      chk("reset pc_target", bus_if.pc_target, 16'h0000);
      chk("reset ir", ir, 16'h0000);
      chk("reset fault", fault, 1'b0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         run              = vecs[i].run;
         bus_if.imem_ack  = vecs[i].ack;
         bus_if.imem_rdata = vecs[i].rdata;
         bus_if.exe_done  = vecs[i].done;
         bus_if.zero_flag = vecs[i].zero;
         stall            = vecs[i].stall;
         bus_if.pc_addr   = vecs[i].pc;
         #1;
         chk($sformatf("r%0d state", i), state, vecs[i].st);
         chk($sformatf("r%0d imem_req", i), bus_if.imem_req, vecs[i].req);
         chk($sformatf("r%0d exe_start", i), bus_if.exe_start, vecs[i].start);
         chk($sformatf("r%0d pc_en", i), bus_if.pc_en, vecs[i].en);
         chk($sformatf("r%0d halted", i), halted, vecs[i].hlt);
         chk($sformatf("r%0d fault", i), fault, vecs[i].flt);
         chk($sformatf("r%0d ir", i), ir, vecs[i].ir);
         if (vecs[i].upd) begin
            chk($sformatf("r%0d pc_jump", i), bus_if.pc_jump, vecs[i].jmp);
            if (vecs[i].jmp)
               chk($sformatf("r%0d pc_target", i), bus_if.pc_target, vecs[i].tgt);
         end
         step();
      end

      // Fetch timeout: 15 unacknowledged FETCH cycles, then HALT with fault.
      bus_if.imem_ack = 1'b0; bus_if.exe_done = 1'b0; stall = 1'b0; run = 1'b0;
      do_reset();
      run = 1'b1;
      step();
      for (int c = 0; c < 15; c++) begin
         chk($sformatf("tmo c%0d state", c), state, 3'd1);
         chk($sformatf("tmo c%0d imem_req", c), bus_if.imem_req, 1'b1);
         chk($sformatf("tmo c%0d fault", c), fault, 1'b0);
         step();
      end
      chk("tmo state", state, 3'd5);
      chk("tmo halted", halted, 1'b1);
      chk("tmo fault", fault, 1'b1);
      chk("tmo imem_req", bus_if.imem_req, 1'b0);
      step();
      chk("tmo run level no exit", state, 3'd5);
      run = 1'b0;
      step();
      run = 1'b1;
      #1;
      chk("tmo before edge", state, 3'd5);
      step();
      chk("tmo refetch state", state, 3'd1);
      chk("tmo refetch req", bus_if.imem_req, 1'b1);
      chk("tmo fault sticky", fault, 1'b1);
      chk("tmo refetch halted", halted, 1'b0);
      bus_if.imem_ack = 1'b1; bus_if.imem_rdata = 16'h1234;
      step();
      bus_if.imem_ack = 1'b0;
      chk("tmo refetch decode", state, 3'd2);
      chk("tmo refetch ir", ir, 16'h1234);
      chk("tmo fault still", fault, 1'b1);

      // Asynchronous reset while pc_en is high in UPDATE.
      do_reset();
      run = 1'b1; bus_if.pc_addr = 16'h3010;
      step();
      bus_if.imem_ack = 1'b1; bus_if.imem_rdata = 16'hC0A5;
      step();
      bus_if.imem_ack = 1'b0;
      step();
      stall = 1'b0;
      #1;
      chk("arst pre state", state, 3'd4);
      chk("arst pre pc_en", bus_if.pc_en, 1'b1);
      chk("arst pre pc_jump", bus_if.pc_jump, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      chk("arst state", state, 3'd0);
      chk("arst pc_en", bus_if.pc_en, 1'b0);
      chk("arst pc_jump", bus_if.pc_jump, 1'b0);
      chk("arst imem_req", bus_if.imem_req, 1'b0);
      chk("arst ir", ir, 16'h0000);
      step();
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
